// File: rtl/bsg_mem_2rw_sync_mask_write_bit_sched.sv
// Two-port request scheduler for a synchronous bit-masked RW/RW memory: serializes same-address
// collisions by priority and buffers each port's read response. Option: BSG_MEM_2RW_SCHED_FIXED_PRIO_EN.
//
// state | meaning
// IDLE  | no read response outstanding
// FRESH | response is on mem_x_data_i this cycle, bypassed to x_data_o
// HELD  | response kept in the port's capture register until yumi
module bsg_mem_2rw_sync_mask_write_bit_sched #(
   parameter int width_p       = 8,
   parameter int els_p         = 16,
   parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
   input  logic                     clk_i,
   input  logic                     reset_i,

   input  logic                     a_v_i,
   input  logic                     a_w_i,
   input  logic [addr_width_lp-1:0] a_addr_i,
   input  logic [width_p-1:0]       a_data_i,
   input  logic [width_p-1:0]       a_w_mask_i,
   output logic                     a_ready_o,
   output logic                     a_v_o,
   output logic [width_p-1:0]       a_data_o,
   input  logic                     a_yumi_i,

   input  logic                     b_v_i,
   input  logic                     b_w_i,
   input  logic [addr_width_lp-1:0] b_addr_i,
   input  logic [width_p-1:0]       b_data_i,
   input  logic [width_p-1:0]       b_w_mask_i,
   output logic                     b_ready_o,
   output logic                     b_v_o,
   output logic [width_p-1:0]       b_data_o,
   input  logic                     b_yumi_i,

   output logic                     mem_a_v_o,
   output logic                     mem_a_w_o,
   output logic [addr_width_lp-1:0] mem_a_addr_o,
   output logic [width_p-1:0]       mem_a_data_o,
   output logic [width_p-1:0]       mem_a_w_mask_o,
   input  logic [width_p-1:0]       mem_a_data_i,

   output logic                     mem_b_v_o,
   output logic                     mem_b_w_o,
   output logic [addr_width_lp-1:0] mem_b_addr_o,
   output logic [width_p-1:0]       mem_b_data_o,
   output logic [width_p-1:0]       mem_b_w_mask_o,
   input  logic [width_p-1:0]       mem_b_data_i
);

   typedef enum logic [1:0] {IDLE, FRESH, HELD} rsp_state_e;

   rsp_state_e         state_q [2];
   rsp_state_e         state_d [2];
   logic [width_p-1:0] cap_q   [2];
   logic [width_p-1:0] cap_d   [2];
   logic [width_p-1:0] mem_rdata [2];

   logic [1:0] v_in, w_in, yumi_in;
   logic [1:0] elig, ready, read_grant;
   logic       conflict, b_wins;

   assign v_in         = {b_v_i, a_v_i};
   assign w_in         = {b_w_i, a_w_i};
   assign yumi_in      = {b_yumi_i, a_yumi_i};
   assign mem_rdata[0] = mem_a_data_i;
   assign mem_rdata[1] = mem_b_data_i;

`ifdef BSG_MEM_2RW_SCHED_FIXED_PRIO_EN
   assign b_wins = 1'b0;
`else
   logic prio_q, prio_d;

   // Toggling on a conflict hands the next conflict to this cycle's loser.
   always_comb begin
      prio_d = prio_q;
      if (conflict) prio_d = ~prio_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) prio_q <= 1'b0;
      else         prio_q <= prio_d;
   end

   assign b_wins = prio_q;
`endif

   // A read may only be accepted when its response slot is empty or being drained now.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         elig[p] = v_in[p] & ~reset_i & (w_in[p] | (state_q[p] == IDLE) | yumi_in[p]);
      end
      conflict   = elig[0] & elig[1] & (a_addr_i == b_addr_i) & (a_w_i | b_w_i);
      ready[0]   = elig[0] & ~(conflict & b_wins);
      ready[1]   = elig[1] & ~(conflict & ~b_wins);
      read_grant = v_in & ready & ~w_in;
   end

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         state_d[p] = state_q[p];
         cap_d[p]   = cap_q[p];
         case (state_q[p])
            IDLE:  if (read_grant[p]) state_d[p] = FRESH;
            FRESH: begin
               if (yumi_in[p]) begin
                  state_d[p] = read_grant[p] ? FRESH : IDLE;
               end else begin
                  state_d[p] = HELD;
                  cap_d[p]   = mem_rdata[p];
               end
            end
            HELD:  if (yumi_in[p]) state_d[p] = read_grant[p] ? FRESH : IDLE;
            default: state_d[p] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      for (int p = 0; p < 2; p++) begin
         if (reset_i) begin
            state_q[p] <= IDLE;
            cap_q[p]   <= '0;
         end else begin
            state_q[p] <= state_d[p];
            cap_q[p]   <= cap_d[p];
         end
      end
   end

   assign a_ready_o = ready[0];
   assign b_ready_o = ready[1];
   assign a_v_o     = (state_q[0] != IDLE) & ~reset_i;
   assign b_v_o     = (state_q[1] != IDLE) & ~reset_i;
   assign a_data_o  = (state_q[0] == FRESH) ? mem_a_data_i : cap_q[0];
   assign b_data_o  = (state_q[1] == FRESH) ? mem_b_data_i : cap_q[1];

   assign mem_a_v_o      = a_v_i & ready[0];
   assign mem_a_w_o      = a_w_i;
   assign mem_a_addr_o   = a_addr_i;
   assign mem_a_data_o   = a_data_i;
   assign mem_a_w_mask_o = a_w_mask_i;

   assign mem_b_v_o      = b_v_i & ready[1];
   assign mem_b_w_o      = b_w_i;
   assign mem_b_addr_o   = b_addr_i;
   assign mem_b_data_o   = b_data_i;
   assign mem_b_w_mask_o = b_w_mask_i;

endmodule

// File: tb/tb_bsg_mem_2rw_sync_mask_write_bit_sched.sv
// Self-checking bench for bsg_mem_2rw_sync_mask_write_bit_sched: behavioural memory plus a
// queue-based reference model, directed scenarios and a randomized run.
module tb_bsg_mem_2rw_sync_mask_write_bit_sched;
   localparam int W  = 8;
   localparam int N  = 16;
   localparam int AW = 4;

   logic clk_i = 1'b0;
   logic reset_i;
   logic a_v_i, a_w_i, a_yumi_i, b_v_i, b_w_i, b_yumi_i;
   logic [AW-1:0] a_addr_i, b_addr_i;
   logic [W-1:0]  a_data_i, a_w_mask_i, b_data_i, b_w_mask_i;
   logic a_ready_o, a_v_o, b_ready_o, b_v_o;
   logic [W-1:0] a_data_o, b_data_o;
   logic mem_a_v_o, mem_a_w_o, mem_b_v_o, mem_b_w_o;
   logic [AW-1:0] mem_a_addr_o, mem_b_addr_o;
   logic [W-1:0] mem_a_data_o, mem_a_w_mask_o, mem_b_data_o, mem_b_w_mask_o;
   logic [W-1:0] mem_a_data_i, mem_b_data_i;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   bsg_mem_2rw_sync_mask_write_bit_sched #(.width_p(W), .els_p(N)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .a_v_i(a_v_i), .a_w_i(a_w_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i),
      .a_w_mask_i(a_w_mask_i), .a_ready_o(a_ready_o), .a_v_o(a_v_o), .a_data_o(a_data_o),
      .a_yumi_i(a_yumi_i),
      .b_v_i(b_v_i), .b_w_i(b_w_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i),
      .b_w_mask_i(b_w_mask_i), .b_ready_o(b_ready_o), .b_v_o(b_v_o), .b_data_o(b_data_o),
      .b_yumi_i(b_yumi_i),
      .mem_a_v_o(mem_a_v_o), .mem_a_w_o(mem_a_w_o), .mem_a_addr_o(mem_a_addr_o),
      .mem_a_data_o(mem_a_data_o), .mem_a_w_mask_o(mem_a_w_mask_o), .mem_a_data_i(mem_a_data_i),
      .mem_b_v_o(mem_b_v_o), .mem_b_w_o(mem_b_w_o), .mem_b_addr_o(mem_b_addr_o),
      .mem_b_data_o(mem_b_data_o), .mem_b_w_mask_o(mem_b_w_mask_o), .mem_b_data_i(mem_b_data_i)
   );

   // Memory behind the scheduler; read data is only meaningful the cycle after a read.
   logic [W-1:0] mem_arr [N];
   always @(posedge clk_i) begin
      if (mem_a_v_o && mem_a_w_o)
         mem_arr[mem_a_addr_o] <= (mem_arr[mem_a_addr_o] & ~mem_a_w_mask_o) | (mem_a_data_o & mem_a_w_mask_o);
      if (mem_b_v_o && mem_b_w_o)
         mem_arr[mem_b_addr_o] <= (mem_arr[mem_b_addr_o] & ~mem_b_w_mask_o) | (mem_b_data_o & mem_b_w_mask_o);
      mem_a_data_i <= (mem_a_v_o && !mem_a_w_o) ? mem_arr[mem_a_addr_o] : W'($urandom);
      mem_b_data_i <= (mem_b_v_o && !mem_b_w_o) ? mem_arr[mem_b_addr_o] : W'($urandom);
   end

   // Reference model: memory contents, per-port queue of pending responses, whose turn it is.
   logic [W-1:0] ref_mem [N];
   logic [W-1:0] qa [$];
   logic [W-1:0] qb [$];
   logic m_b_turn;
   logic m_ra, m_rb, m_conf;

   task automatic model_eval();
      logic ea, eb, a_wins;
      ea = a_v_i && !reset_i && (a_w_i || qa.size() == 0 || a_yumi_i);
      eb = b_v_i && !reset_i && (b_w_i || qb.size() == 0 || b_yumi_i);
      m_conf = ea && eb && (a_addr_i == b_addr_i) && (a_w_i || b_w_i);
`ifdef BSG_MEM_2RW_SCHED_FIXED_PRIO_EN
      a_wins = 1'b1;
`else
      a_wins = !m_b_turn;
`endif
      m_ra = ea && !(m_conf && !a_wins);
      m_rb = eb && !(m_conf && a_wins);
   endtask

   task automatic model_update();
      logic [W-1:0] rda, rdb;
      if (reset_i) begin
         qa.delete();
         qb.delete();
         m_b_turn = 1'b0;
      end else begin
         rda = ref_mem[a_addr_i];
         rdb = ref_mem[b_addr_i];
         if (a_yumi_i && qa.size() != 0) void'(qa.pop_front());
         if (b_yumi_i && qb.size() != 0) void'(qb.pop_front());
         if (m_ra && !a_w_i) qa.push_back(rda);
         if (m_rb && !b_w_i) qb.push_back(rdb);
         if (m_ra && a_w_i) ref_mem[a_addr_i] = (rda & ~a_w_mask_i) | (a_data_i & a_w_mask_i);
         if (m_rb && b_w_i) ref_mem[b_addr_i] = (rdb & ~b_w_mask_i) | (b_data_i & b_w_mask_i);
         if (m_conf) m_b_turn = !m_b_turn;
      end
   endtask

   task automatic tick();
      model_eval();
      @(posedge clk_i);
      model_update();
      #1;
   endtask

   task automatic idle();
      a_v_i = 0; a_w_i = 0; a_addr_i = '0; a_data_i = '0; a_w_mask_i = '1; a_yumi_i = 0;
      b_v_i = 0; b_w_i = 0; b_addr_i = '0; b_data_i = '0; b_w_mask_i = '1; b_yumi_i = 0;
   endtask

   task automatic test_reset();
      reset_i = 1;
      idle();
      a_v_i = 1; b_v_i = 1; b_w_i = 1; b_addr_i = 4'd9;
      #1;
      checks++;
      if ({a_ready_o, b_ready_o, mem_a_v_o, mem_b_v_o, a_v_o, b_v_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=000000",
                  {a_ready_o, b_ready_o, mem_a_v_o, mem_b_v_o, a_v_o, b_v_o});
      end
      tick(); tick();
      reset_i = 0;
      idle();
      #1;
      checks++;
      if ({a_v_o, b_v_o} !== 2'b00) begin
         errors++; $display("FAIL reset_v_after got=%b exp=00", {a_v_o, b_v_o});
      end
   endtask

   task automatic test_ww_conflict();
      logic exp_a;
      logic [W-1:0] exp_final;
      idle();
      a_v_i = 1; a_w_i = 1; a_addr_i = 4'd7; a_data_i = 8'h11;
      b_v_i = 1; b_w_i = 1; b_addr_i = 4'd7; b_data_i = 8'h22;
      #1;
      checks++;
      if ({a_ready_o, b_ready_o} !== 2'b10) begin
         errors++; $display("FAIL ww_first got=%b exp=10", {a_ready_o, b_ready_o});
      end
      tick();
      a_v_i = 0;
      #1;
      checks++;
      if (b_ready_o !== 1'b1) begin
         errors++; $display("FAIL ww_stalled_b got=%b exp=1", b_ready_o);
      end
      tick();
      a_v_i = 1; a_data_i = 8'h33; b_data_i = 8'h44;
`ifdef BSG_MEM_2RW_SCHED_FIXED_PRIO_EN
      exp_a = 1'b1; exp_final = 8'h44;
`else
      exp_a = 1'b0; exp_final = 8'h33;
`endif
      #1;
      checks++;
      if ({a_ready_o, b_ready_o} !== {exp_a, !exp_a}) begin
         errors++; $display("FAIL ww_second got=%b exp=%b", {a_ready_o, b_ready_o}, {exp_a, !exp_a});
      end
      tick();
      if (exp_a) a_v_i = 0; else b_v_i = 0;
      #1;
      checks++;
      if ((a_ready_o | b_ready_o) !== 1'b1) begin
         errors++; $display("FAIL ww_loser_issue got=%b%b exp=one high", a_ready_o, b_ready_o);
      end
      tick();
      idle();
      a_v_i = 1; a_addr_i = 4'd7;
      tick();
      a_v_i = 0; a_yumi_i = 1;
      #1;
      checks++;
      if (a_data_o !== exp_final) begin
         errors++; $display("FAIL ww_final got=%h exp=%h", a_data_o, exp_final);
      end
      tick();
      idle();
   endtask

   task automatic test_single_read();
      idle();
      a_v_i = 1; a_w_i = 1; a_addr_i = 4'd3; a_data_i = 8'hFF;
      #1;
      checks++;
      if ({a_ready_o, mem_a_v_o} !== 2'b11) begin
         errors++; $display("FAIL sr_write_issue got=%b exp=11", {a_ready_o, mem_a_v_o});
      end
      tick();
      a_w_i = 0;
      #1;
      checks++;
      if ({a_ready_o, a_v_o} !== 2'b10) begin
         errors++; $display("FAIL sr_read_issue got=%b exp=10", {a_ready_o, a_v_o});
      end
      tick();
      a_v_i = 0; a_yumi_i = 1;
      #1;
      checks++;
      if (a_v_o !== 1'b1 || a_data_o !== 8'hFF) begin
         errors++; $display("FAIL sr_response got v=%b d=%h exp v=1 d=ff", a_v_o, a_data_o);
      end
      tick();
      a_yumi_i = 0;
      #1;
      checks++;
      if (a_v_o !== 1'b0) begin
         errors++; $display("FAIL sr_drained got=%b exp=0", a_v_o);
      end
   endtask

   task automatic test_held();
      idle();
      b_v_i = 1; b_w_i = 1; b_addr_i = 4'd5; b_data_i = 8'h5A;
      tick();
      b_w_i = 0;
      tick();
      for (int k = 0; k < 4; k++) begin
         b_v_i = 1; b_w_i = 0; b_addr_i = 4'd6; b_yumi_i = 0;
         a_v_i = 1; a_w_i = 1; a_addr_i = 4'd5; a_data_i = 8'h80 + W'(k * 8'h11);
         #1;
         checks++;
         if (b_v_o !== 1'b1 || b_data_o !== 8'h5A) begin
            errors++; $display("FAIL held_data k=%0d got v=%b d=%h exp v=1 d=5a", k, b_v_o, b_data_o);
         end
         checks++;
         if ({a_ready_o, b_ready_o} !== 2'b10) begin
            errors++; $display("FAIL held_ready k=%0d got=%b exp=10", k, {a_ready_o, b_ready_o});
         end
         tick();
      end
      a_v_i = 0; b_yumi_i = 1;
      #1;
      checks++;
      if (b_ready_o !== 1'b1 || b_data_o !== 8'h5A) begin
         errors++; $display("FAIL held_yumi got rdy=%b d=%h exp rdy=1 d=5a", b_ready_o, b_data_o);
      end
      tick();
      b_v_i = 0; b_yumi_i = 1;
      #1;
      checks++;
      if (b_v_o !== 1'b1 || b_data_o !== qb[0]) begin
         errors++; $display("FAIL held_next got v=%b d=%h exp v=1 d=%h", b_v_o, b_data_o, qb[0]);
      end
      tick();
      idle();
   endtask

   task automatic test_rr_same();
      idle();
      a_v_i = 1; a_w_i = 1; a_addr_i = 4'd2; a_data_i = 8'hA7;
      tick();
      a_w_i = 0; b_v_i = 1; b_addr_i = 4'd2;
      #1;
      checks++;
      if ({a_ready_o, b_ready_o} !== 2'b11) begin
         errors++; $display("FAIL rr_issue got=%b exp=11", {a_ready_o, b_ready_o});
      end
      tick();
      idle();
      a_yumi_i = 1; b_yumi_i = 1;
      #1;
      checks++;
      if ({a_v_o, b_v_o} !== 2'b11 || a_data_o !== 8'hA7 || b_data_o !== 8'hA7) begin
         errors++; $display("FAIL rr_data got v=%b a=%h b=%h exp v=11 a=a7 b=a7",
                            {a_v_o, b_v_o}, a_data_o, b_data_o);
      end
      tick();
      idle();
   endtask

   task automatic test_masked_write();
      idle();
      a_v_i = 1; a_w_i = 1; a_addr_i = 4'd1; a_data_i = 8'h00; a_w_mask_i = 8'hFF;
      tick();
      a_data_i = 8'hF0; a_w_mask_i = 8'h3C;
      tick();
      a_w_i = 0;
      tick();
      a_v_i = 0; a_yumi_i = 1;
      #1;
      checks++;
      if (a_data_o !== 8'h30) begin
         errors++; $display("FAIL mask_readback got=%h exp=30", a_data_o);
      end
      tick();
      idle();
   endtask

   task automatic test_reset_mid();
      idle();
      a_v_i = 1; a_addr_i = 4'd1;
      tick();
      a_v_i = 0;
      tick();
      #1;
      checks++;
      if (a_v_o !== 1'b1 || a_data_o !== 8'h30) begin
         errors++; $display("FAIL rm_held got v=%b d=%h exp v=1 d=30", a_v_o, a_data_o);
      end
      reset_i = 1;
      tick();
      reset_i = 0;
      #1;
      checks++;
      if (a_v_o !== 1'b0) begin
         errors++; $display("FAIL rm_discard got=%b exp=0", a_v_o);
      end
      a_v_i = 1;
      tick();
      a_v_i = 0; a_yumi_i = 1;
      #1;
      checks++;
      if (a_v_o !== 1'b1 || a_data_o !== 8'h30) begin
         errors++; $display("FAIL rm_reread got v=%b d=%h exp v=1 d=30", a_v_o, a_data_o);
      end
      tick();
      idle();
   endtask

   task automatic test_random();
      logic ev_a, ev_b;
      for (int i = 0; i < 500; i++) begin
         reset_i    = ($urandom_range(0, 59) == 0);
         a_v_i      = ($urandom_range(0, 3) != 0);
         a_w_i      = $urandom_range(0, 1) == 1;
         a_addr_i   = AW'($urandom_range(0, 3));
         a_data_i   = W'($urandom);
         a_w_mask_i = W'($urandom);
         a_yumi_i   = !reset_i && qa.size() != 0 && ($urandom_range(0, 2) != 0);
         b_v_i      = ($urandom_range(0, 3) != 0);
         b_w_i      = $urandom_range(0, 1) == 1;
         b_addr_i   = AW'($urandom_range(0, 3));
         b_data_i   = W'($urandom);
         b_w_mask_i = W'($urandom);
         b_yumi_i   = !reset_i && qb.size() != 0 && ($urandom_range(0, 2) != 0);
         model_eval();
         ev_a = !reset_i && qa.size() != 0;
         ev_b = !reset_i && qb.size() != 0;
         #1;
         checks++;
         if ({a_ready_o, b_ready_o} !== {m_ra, m_rb}) begin
            errors++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, {a_ready_o, b_ready_o}, {m_ra, m_rb});
         end
         checks++;
         if ({mem_a_v_o, mem_b_v_o} !== {m_ra, m_rb}) begin
            errors++; $display("FAIL rnd_mem_v i=%0d got=%b exp=%b", i, {mem_a_v_o, mem_b_v_o}, {m_ra, m_rb});
         end
         checks++;
         if ({a_v_o, b_v_o} !== {ev_a, ev_b}) begin
            errors++; $display("FAIL rnd_v_o i=%0d got=%b exp=%b", i, {a_v_o, b_v_o}, {ev_a, ev_b});
         end
         if (ev_a) begin
            checks++;
            if (a_data_o !== qa[0]) begin
               errors++; $display("FAIL rnd_a_data i=%0d got=%h exp=%h", i, a_data_o, qa[0]);
            end
         end
         if (ev_b) begin
            checks++;
            if (b_data_o !== qb[0]) begin
               errors++; $display("FAIL rnd_b_data i=%0d got=%h exp=%h", i, b_data_o, qb[0]);
            end
         end
         tick();
      end
      reset_i = 0;
      idle();
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         mem_arr[i] = '0;
         ref_mem[i] = '0;
      end
      mem_a_data_i = '0;
      mem_b_data_i = '0;
      m_b_turn = 1'b0;
      m_ra = 0; m_rb = 0; m_conf = 0;
      reset_i = 1;
      idle();
      test_reset();
      test_ww_conflict();
      test_single_read();
      test_held();
      test_rr_same();
      test_masked_write();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
